// File: rtl/oai22_stim_sequencer_if.sv
// Stimulus/observe bundle between an OAI22 sequencer and its harness.
// master = sequencer side, slave = harness / cell side.
interface oai22_stim_sequencer_if #(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
);
    logic               START;
    logic [DWELL_W-1:0] DWELL;
    logic [7:0]         NPASS;
    logic               QN;
    logic               IN1;
    logic               IN2;
    logic               IN3;
    logic               IN4;
    logic               BUSY;
    logic               DONE;
    logic [CNT_W-1:0]   ERR_CNT;
    logic [CNT_W-1:0]   TOG_CNT;

    modport master (
        input  START, DWELL, NPASS, QN,
        output IN1, IN2, IN3, IN4,
        output BUSY, DONE, ERR_CNT, TOG_CNT
    );

    modport slave (
        output START, DWELL, NPASS, QN,
        input  IN1, IN2, IN3, IN4,
        input  BUSY, DONE, ERR_CNT, TOG_CNT
    );
endinterface

// File: rtl/oai22_stim_sequencer.sv
// Per-cell OAI22 stimulus sweep, QN check, mismatch and toggle counting.
// Define OAI22_SEQ_GRAY_EN for a Gray-code sweep order (binary otherwise).
module oai22_stim_sequencer #(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    oai22_stim_sequencer_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state;
    logic [3:0]         vec;
    logic [3:0]         in_r;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_lat;
    logic [7:0]         pass_rem;
    logic               last_qn;
    logic               first_flag;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   err;
    logic [CNT_W-1:0]   tog;

    function automatic logic [3:0] appl(input logic [3:0] v);
`ifdef OAI22_SEQ_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    logic [3:0] cur;
    logic       exp_qn;
    logic [3:0] vec_nx;

    assign cur    = appl(vec);
    assign exp_qn = ~((cur[0] | cur[1]) & (cur[2] | cur[3]));
    assign vec_nx = vec + 4'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            vec        <= 4'd0;
            in_r       <= 4'd0;
            dwell_cnt  <= '0;
            dwell_lat  <= '0;
            pass_rem   <= 8'd0;
            last_qn    <= 1'b0;
            first_flag <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= '0;
            tog        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        dwell_lat  <= bus.DWELL;
                        dwell_cnt  <= bus.DWELL;
                        pass_rem   <= bus.NPASS;
                        vec        <= 4'd0;
                        in_r       <= appl(4'd0);
                        err        <= '0;
                        tog        <= '0;
                        first_flag <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (dwell_cnt == '0)
                        state <= CHECK;
                    else
                        dwell_cnt <= dwell_cnt - 1'b1;
                end
                CHECK: begin
                    if (bus.QN != exp_qn && err != '1)
                        err <= err + 1'b1;
                    if (!first_flag && bus.QN != last_qn && tog != '1)
                        tog <= tog + 1'b1;
                    last_qn    <= bus.QN;
                    first_flag <= 1'b0;
                    dwell_cnt  <= dwell_lat;
                    // last_qn survives the 15->0 wrap so it counts as a toggle
                    if (vec != 4'hf) begin
                        vec   <= vec_nx;
                        in_r  <= appl(vec_nx);
                        state <= SETTLE;
                    end else if (pass_rem != 8'd0) begin
                        pass_rem <= pass_rem - 8'd1;
                        vec      <= 4'd0;
                        in_r     <= appl(4'd0);
                        state    <= SETTLE;
                    end else begin
                        in_r  <= 4'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.IN1     = in_r[0];
    assign bus.IN2     = in_r[1];
    assign bus.IN3     = in_r[2];
    assign bus.IN4     = in_r[3];
    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.ERR_CNT = err;
    assign bus.TOG_CNT = tog;
endmodule

// File: tb/tb_oai22_stim_sequencer.sv
// Directed bench for oai22_stim_sequencer with a run-level scoreboard.
// Tracks binary or Gray sweep order from OAI22_SEQ_GRAY_EN.
module tb_oai22_stim_sequencer;
    logic clk;
    logic rst;
    logic tie_lo;

    oai22_stim_sequencer_if #(.DWELL_W(8), .CNT_W(16)) bus ();

    oai22_stim_sequencer #(.DWELL_W(8), .CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ideal OAI22 cell, optionally stuck at 0
    assign bus.QN = tie_lo ? 1'b0 :
        ~((bus.IN1 | bus.IN2) & (bus.IN3 | bus.IN4));

    typedef struct {
        int busy;
        int dwell;
        int err;
        int tog;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   bcnt   = 0;
    int   vbad   = 0;
    int   ndone  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] appl(input int i);
        logic [3:0] v;
        v = i[3:0];
`ifdef OAI22_SEQ_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic exp_t model(input int dwell, input int npass,
                                   input bit tie);
        exp_t       r;
        logic [3:0] a;
        bit         x, q, last, first;
        r.busy  = (npass + 1) * 16 * (dwell + 2);
        r.dwell = dwell;
        r.err   = 0;
        r.tog   = 0;
        first   = 1;
        last    = 0;
        for (int p = 0; p <= npass; p++) begin
            for (int i = 0; i < 16; i++) begin
                a = appl(i);
                x = ~((a[0] | a[1]) & (a[2] | a[3]));
                q = tie ? 1'b0 : x;
                if (q != x) r.err++;
                if (!first && q != last) r.tog++;
                last  = q;
                first = 0;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] invec();
        return {bus.IN4, bus.IN3, bus.IN2, bus.IN1};
    endfunction

    // run monitor: vector order/hold per busy cycle, scoreboard pop on DONE
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (rst) begin
            bcnt = 0;
            vbad = 0;
        end else begin
            if (bus.BUSY) begin
                if (sb.size() > 0) begin
                    idx = (bcnt / (sb[0].dwell + 2)) % 16;
                    if (invec() !== appl(idx)) vbad++;
                end
                bcnt++;
            end
            if (bus.DONE) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("busy_cycles", bcnt, e.busy);
                    check("vector_seq", vbad, 0);
                    check("done_busy_low", bus.BUSY, 0);
                    check("err_cnt", bus.ERR_CNT, e.err);
                    check("tog_cnt", bus.TOG_CNT, e.tog);
                end
                bcnt = 0;
                vbad = 0;
                ndone++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run(input int dwell, input int npass, input bit tie,
                       output exp_t e);
        e           = model(dwell, npass, tie);
        tie_lo      = tie;
        bus.DWELL   = 8'(dwell);
        bus.NPASS   = 8'(npass);
        bus.START   = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.START   = 1'b0;
        #1;
        check("start_busy", bus.BUSY, 1);
    endtask

    // cycles counted from the negedge after the accepting edge
    task automatic wait_done(input string tag, input int exp_cyc);
        int n0;
        int c;
        n0 = ndone;
        c  = 0;
        while (ndone == n0 && c < exp_cyc + 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        check({tag, "_done_seen"}, (ndone != n0), 1);
        check({tag, "_done_cycle"}, c, exp_cyc);
        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, bus.DONE, 0);
        check({tag, "_idle_in"}, invec(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, bus.BUSY, 0);
        check({tag, "_done"}, bus.DONE, 0);
        check({tag, "_in"}, invec(), 0);
        check({tag, "_err"}, bus.ERR_CNT, 0);
        check({tag, "_tog"}, bus.TOG_CNT, 0);
    endtask

    initial begin
        exp_t e;
        int   n0;
        rst       = 1'b1;
        tie_lo    = 1'b0;
        bus.START = 1'b0;
        bus.DWELL = 8'd0;
        bus.NPASS = 8'd0;
        tick(3);
        #1;
        check_idle("reset");
        rst = 1'b0;
        tick(2);

        // one sweep, minimum dwell
        run(0, 0, 0, e);
        wait_done("d0p0", e.busy);

        // two sweeps, wrap toggle counted
        run(0, 1, 0, e);
        wait_done("d0p1", e.busy);

        // longer dwell
        run(3, 0, 0, e);
        wait_done("d3p0", e.busy);

        // stuck-at-0 cell
        run(0, 0, 1, e);
        wait_done("tie0", e.busy);
        tick(5);
        #1;
        check("hold_err", bus.ERR_CNT, e.err);
        check("hold_tog", bus.TOG_CNT, e.tog);
        check("hold_busy", bus.BUSY, 0);

        // START and DWELL changes while busy are ignored
        run(1, 0, 0, e);
        tick(10);
        bus.START = 1'b1;
        bus.DWELL = 8'd5;
        bus.NPASS = 8'd3;
        @(negedge clk);
        bus.START = 1'b0;
        wait_done("repulse", e.busy - 11);

        // reset during SETTLE of vector 7
        run(2, 0, 1, e);
        tick(28);
        #1;
        check("pre_rst_vec", invec(), appl(7));
        check("pre_rst_err", (bus.ERR_CNT != 0), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check_idle("midrst");
        n0 = ndone;
        tick(80);
        check("no_done_after_rst", ndone, n0);

        // fresh run after abort
        run(0, 0, 0, e);
        wait_done("after_rst", e.busy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
